airi5c_wb_scoreboard: RTL and testbench

- Writeback-side companion of the register file.
- Tracks destination registers of issued long-latency operations (loads, divider, 64-bit MUL results) in a 32-bit scoreboard and raises hazard_o for dependent reads or writes.
- Buffers completed long-latency results in a small FIFO and drains them into the single register-file write port in cycles the in-order pipeline writeback does not use.
- Drives the register file's wen/wa/wd/wd2/use_rd64 inputs.

---
 rtl/airi5c_wb_scoreboard_pkg.sv | 34 +++
 rtl/airi5c_wb_fifo.sv | 58 +++++
 rtl/airi5c_wb_scoreboard_chk.sv | 12 +
 rtl/airi5c_wb_scoreboard.sv | 151 +++++++++++++++
 tb/tb_airi5c_wb_scoreboard.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/airi5c_wb_scoreboard_pkg.sv
// Shared widths, result-buffer entry layout and register-mask helper for the writeback scoreboard.
// Optional forwarding (macro AIRI5C_WB_FORWARD_EN) is handled in the top; nothing here depends on it.
package airi5c_wb_scoreboard_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int XPR_LEN        = 32;
  localparam int WB_FIFO_DEPTH  = 2;
  localparam int WB_ENTRY_WIDTH = 2*XPR_LEN + REG_ADDR_WIDTH + 1;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rd64;
    logic [XPR_LEN-1:0]        wd;
    logic [XPR_LEN-1:0]        wd2;
  } wb_entry_t;

  // One-hot mask of rd (and rd+1 mod 32 for a pair); x0 is never tracked.
  function automatic logic [31:0] reg_mask(input logic [REG_ADDR_WIDTH-1:0] rd,
                                           input logic                      rd64);
    logic [31:0]               m;
    logic [REG_ADDR_WIDTH-1:0] rd_hi;
    m        = 32'd0;
    rd_hi    = rd + REG_ADDR_WIDTH'(1);
    m[rd]    = 1'b1;
    if (rd64) begin
      m[rd_hi] = 1'b1;
    end else begin
      m = m;
    end
    m[0]     = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/airi5c_wb_fifo.sv
// Generic synchronous FIFO with async active-low reset; registered storage, no push-through.
// Push while full is accepted only together with a pop.
module airi5c_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == (AW+1)'(0));
  assign count_o = count;
  assign rdata_o = mem[rd_ptr];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata_i;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/airi5c_wb_scoreboard_chk.sv
// Simulation checker: the pipeline never writes back while the debug module owns the write port.
module airi5c_wb_scoreboard_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic pipe_wen_i,
  input logic dm_wen_i
);

  a_no_pipe_during_dm: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                        !(pipe_wen_i && dm_wen_i));

endmodule

// File: rtl/airi5c_wb_scoreboard.sv
// Writeback scoreboard: tracks long-latency destinations, buffers their results and drains them
// into free register-file write slots. Define AIRI5C_WB_FORWARD_EN for drain-cycle forwarding.
module airi5c_wb_scoreboard
  import airi5c_wb_scoreboard_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int FIFO_AW    = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      issue_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd_i,
  input  logic                      issue_rd64_i,
  input  logic [REG_ADDR_WIDTH-1:0] ra1_i,
  input  logic [REG_ADDR_WIDTH-1:0] ra2_i,
  input  logic [REG_ADDR_WIDTH-1:0] ra3_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_chk_i,
  output logic                      hazard_o,
  input  logic                      lres_valid_i,
  output logic                      lres_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] lres_rd_i,
  input  logic                      lres_rd64_i,
  input  logic [XPR_LEN-1:0]        lres_wd_i,
  input  logic [XPR_LEN-1:0]        lres_wd2_i,
  input  logic                      pipe_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_wa_i,
  input  logic [XPR_LEN-1:0]        pipe_wd_i,
  input  logic                      dm_wen_i,
  output logic                      wen_o,
  output logic [REG_ADDR_WIDTH-1:0] wa_o,
  output logic [XPR_LEN-1:0]        wd_o,
  output logic [XPR_LEN-1:0]        wd2_o,
  output logic                      use_rd64_o,
  output logic                      busy_o
`ifdef AIRI5C_WB_FORWARD_EN
  ,
  output logic                      fwd1_o,
  output logic                      fwd2_o,
  output logic                      fwd3_o,
  output logic [XPR_LEN-1:0]        fwd_data_o,
  output logic [XPR_LEN-1:0]        fwd_data2_o
`endif
);

  wb_entry_t    in_entry;
  wb_entry_t    head;
  logic [FIFO_AW:0] count;
  logic         full;
  logic         empty;
  logic         push;
  logic         drain;
  logic [31:0]  sb;
  logic [31:0]  set_mask;
  logic [31:0]  clr_mask;
  logic [2:0]   fwd;

  assign in_entry     = {lres_rd_i, lres_rd64_i, lres_wd_i, lres_wd2_i};
  assign lres_ready_o = !full;
  assign push         = lres_valid_i && lres_ready_o;
  assign busy_o       = (|sb) || (count != (FIFO_AW+1)'(0));

  airi5c_wb_fifo #(
    .WIDTH(WB_ENTRY_WIDTH),
    .DEPTH(FIFO_DEPTH),
    .AW   (FIFO_AW)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .pop_i  (drain),
    .wdata_i(in_entry),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );

  airi5c_wb_scoreboard_chk u_chk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .pipe_wen_i(pipe_wen_i),
    .dm_wen_i  (dm_wen_i)
  );

  // Write-port arbitration: debug, then pipeline, then buffered results.
  always_comb begin
    drain      = 1'b0;
    wen_o      = 1'b0;
    wa_o       = '0;
    wd_o       = '0;
    wd2_o      = '0;
    use_rd64_o = 1'b0;
    if (dm_wen_i) begin
      drain = 1'b0;
    end else if (pipe_wen_i) begin
      wen_o = 1'b1;
      wa_o  = pipe_wa_i;
      wd_o  = pipe_wd_i;
    end else if (!empty) begin
      drain      = 1'b1;
      wen_o      = 1'b1;
      wa_o       = head.rd;
      wd_o       = head.wd;
      wd2_o      = head.wd2;
      use_rd64_o = head.rd64;
    end else begin
      wen_o = 1'b0;
    end
  end

  // Masks of bits being set by issue and cleared by drain this cycle.
  always_comb begin
    set_mask = 32'd0;
    clr_mask = 32'd0;
    if (issue_valid_i) begin
      set_mask = reg_mask(issue_rd_i, issue_rd64_i);
    end else begin
      set_mask = 32'd0;
    end
    if (drain) begin
      clr_mask = reg_mask(head.rd, head.rd64);
    end else begin
      clr_mask = 32'd0;
    end
  end

  // Scoreboard register; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb <= 32'd0;
    end else begin
      sb <= (sb & ~clr_mask) | set_mask;
    end
  end

`ifdef AIRI5C_WB_FORWARD_EN
  // clr_mask bit 0 is always clear, so x0 never forwards.
  assign fwd         = {clr_mask[ra3_i], clr_mask[ra2_i], clr_mask[ra1_i]};
  assign fwd1_o      = fwd[0];
  assign fwd2_o      = fwd[1];
  assign fwd3_o      = fwd[2];
  assign fwd_data_o  = head.wd;
  assign fwd_data2_o = head.wd2;
`else
  assign fwd = 3'b000;
`endif

  assign hazard_o = (sb[ra1_i] && !fwd[0]) || (sb[ra2_i] && !fwd[1]) ||
                    (sb[ra3_i] && !fwd[2]) || sb[rd_chk_i];

endmodule

// File: tb/tb_airi5c_wb_scoreboard.sv
// Self-checking bench for airi5c_wb_scoreboard: expected register-file writes are queued by the
// stimulus and checked by a monitor; AIRI5C_WB_FORWARD_EN selects the forwarding expectations.
module tb_airi5c_wb_scoreboard;
  import airi5c_wb_scoreboard_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i, issue_rd64_i;
  logic [4:0]  issue_rd_i, ra1_i, ra2_i, ra3_i, rd_chk_i;
  logic        hazard_o;
  logic        lres_valid_i, lres_ready_o, lres_rd64_i;
  logic [4:0]  lres_rd_i;
  logic [31:0] lres_wd_i, lres_wd2_i;
  logic        pipe_wen_i;
  logic [4:0]  pipe_wa_i;
  logic [31:0] pipe_wd_i;
  logic        dm_wen_i;
  logic        wen_o, use_rd64_o, busy_o;
  logic [4:0]  wa_o;
  logic [31:0] wd_o, wd2_o;
`ifdef AIRI5C_WB_FORWARD_EN
  logic        fwd1_o, fwd2_o, fwd3_o;
  logic [31:0] fwd_data_o, fwd_data2_o;
`endif

  typedef struct packed {
    logic [4:0]  wa;
    logic        r64;
    logic [31:0] wd;
    logic [31:0] wd2;
  } wr_t;

  wr_t exp_q[$];
  wr_t exp_e;
  int  checks = 0;
  int  errors = 0;

  always #5 clk_i = ~clk_i;

  airi5c_wb_scoreboard dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_rd64_i(issue_rd64_i),
    .ra1_i(ra1_i), .ra2_i(ra2_i), .ra3_i(ra3_i), .rd_chk_i(rd_chk_i), .hazard_o(hazard_o),
    .lres_valid_i(lres_valid_i), .lres_ready_o(lres_ready_o), .lres_rd_i(lres_rd_i),
    .lres_rd64_i(lres_rd64_i), .lres_wd_i(lres_wd_i), .lres_wd2_i(lres_wd2_i),
    .pipe_wen_i(pipe_wen_i), .pipe_wa_i(pipe_wa_i), .pipe_wd_i(pipe_wd_i), .dm_wen_i(dm_wen_i),
    .wen_o(wen_o), .wa_o(wa_o), .wd_o(wd_o), .wd2_o(wd2_o), .use_rd64_o(use_rd64_o),
    .busy_o(busy_o)
`ifdef AIRI5C_WB_FORWARD_EN
    , .fwd1_o(fwd1_o), .fwd2_o(fwd2_o), .fwd3_o(fwd3_o),
    .fwd_data_o(fwd_data_o), .fwd_data2_o(fwd_data2_o)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd,
                           input logic [31:0] wd2, input logic r64);
    exp_q.push_back({wa, r64, wd, wd2});
  endtask

  task automatic idle();
    issue_valid_i = 1'b0; issue_rd_i = 5'd0; issue_rd64_i = 1'b0;
    ra1_i = 5'd0; ra2_i = 5'd0; ra3_i = 5'd0; rd_chk_i = 5'd0;
    lres_valid_i = 1'b0; lres_rd_i = 5'd0; lres_rd64_i = 1'b0;
    lres_wd_i = 32'd0; lres_wd2_i = 32'd0;
    pipe_wen_i = 1'b0; pipe_wa_i = 5'd0; pipe_wd_i = 32'd0; dm_wen_i = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
    idle();
  endtask

  // Monitor: every register-file write must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rst_ni && wen_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: wa=%0d wd=0x%0h, expected no write", wa_o, wd_o);
      end else begin
        exp_e = exp_q.pop_front();
        if ({wa_o, use_rd64_o, wd_o, wd2_o} !== exp_e) begin
          errors++;
          $display("FAIL write: got wa=%0d r64=%0b wd=0x%0h wd2=0x%0h, expected wa=%0d r64=%0b wd=0x%0h wd2=0x%0h",
                   wa_o, use_rd64_o, wd_o, wd2_o, exp_e.wa, exp_e.r64, exp_e.wd, exp_e.wd2);
        end
      end
    end
  end

  initial begin
    idle();
    rst_ni = 1'b0;
    #12;
    chk("rst_hazard", 32'(hazard_o), 32'd0);
    chk("rst_ready", 32'(lres_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_wen", 32'(wen_o), 32'd0);
    cyc();
    rst_ni = 1'b1;

    // Reset mid-operation.
    cyc();
    issue_valid_i = 1'b1; issue_rd_i = 5'd5;
    cyc();
    lres_valid_i = 1'b1; lres_rd_i = 5'd5; lres_wd_i = 32'h0000_00AA;
    pipe_wen_i = 1'b1; pipe_wa_i = 5'd1; pipe_wd_i = 32'h11;
    expect_wr(5'd1, 32'h11, 32'd0, 1'b0);
    cyc();
    ra1_i = 5'd5;
    #1;
    chk("mid_busy_before_rst", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_hazard", 32'(hazard_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_wen", 32'(wen_o), 32'd0);
    chk("mid_rst_ready", 32'(lres_ready_o), 32'd1);
    cyc();
    rst_ni = 1'b1;

    // Basic load hazard and drain.
    cyc();
    issue_valid_i = 1'b1; issue_rd_i = 5'd7;
    cyc();
    ra1_i = 5'd7;
    lres_valid_i = 1'b1; lres_rd_i = 5'd7; lres_wd_i = 32'h1234;
    #1;
    chk("load_hazard", 32'(hazard_o), 32'd1);
    chk("load_no_write_yet", 32'(wen_o), 32'd0);
    expect_wr(5'd7, 32'h1234, 32'd0, 1'b0);
    cyc();
    ra1_i = 5'd7;
    #1;
`ifdef AIRI5C_WB_FORWARD_EN
    chk("load_drain_fwd1", 32'(fwd1_o), 32'd1);
    chk("load_drain_fwd_data", fwd_data_o, 32'h1234);
    chk("load_drain_hazard", 32'(hazard_o), 32'd0);
`else
    chk("load_drain_hazard", 32'(hazard_o), 32'd1);
`endif
    cyc();
    ra1_i = 5'd7;
    #1;
    chk("load_after_hazard", 32'(hazard_o), 32'd0);
    chk("load_after_busy", 32'(busy_o), 32'd0);

    // Arbitration: pipeline writes win over a buffered result.
    cyc();
    lres_valid_i = 1'b1; lres_rd_i = 5'd3; lres_wd_i = 32'h33;
    for (int i = 0; i < 2; i++) begin
      cyc();
      pipe_wen_i = 1'b1; pipe_wa_i = 5'd4; pipe_wd_i = 32'h44 + 32'(i);
      expect_wr(5'd4, 32'h44 + 32'(i), 32'd0, 1'b0);
      #1;
      chk("arb_fifo_held", 32'(busy_o), 32'd1);
    end
    cyc();
    expect_wr(5'd3, 32'h33, 32'd0, 1'b0);
    cyc();
    #1;
    chk("arb_drained", 32'(busy_o), 32'd0);

    // Pair wrap at x31.
    cyc();
    issue_valid_i = 1'b1; issue_rd_i = 5'd31; issue_rd64_i = 1'b1;
    cyc();
    ra2_i = 5'd31;
    #1;
    chk("pair_hazard_31", 32'(hazard_o), 32'd1);
    ra2_i = 5'd0;
    #1;
    chk("pair_hazard_0", 32'(hazard_o), 32'd0);
    lres_valid_i = 1'b1; lres_rd_i = 5'd31; lres_rd64_i = 1'b1;
    lres_wd_i = 32'hA0A0_0001; lres_wd2_i = 32'hB0B0_0002;
    expect_wr(5'd31, 32'hA0A0_0001, 32'hB0B0_0002, 1'b1);
    cyc();
    cyc();
    ra2_i = 5'd31;
    #1;
    chk("pair_cleared", 32'(hazard_o), 32'd0);

    // Full FIFO under sustained pipeline writeback.
    for (int i = 0; i < 3; i++) begin
      cyc();
      pipe_wen_i = 1'b1; pipe_wa_i = 5'd10; pipe_wd_i = 32'hA0 + 32'(i);
      expect_wr(5'd10, 32'hA0 + 32'(i), 32'd0, 1'b0);
      lres_valid_i = 1'b1; lres_rd_i = 5'd12 + 5'(i); lres_wd_i = 32'hC1 + 32'(i);
      #1;
      chk("full_ready", 32'(lres_ready_o), (i < 2) ? 32'd1 : 32'd0);
    end
    cyc();
    lres_valid_i = 1'b1; lres_rd_i = 5'd14; lres_wd_i = 32'hC3;
    expect_wr(5'd12, 32'hC1, 32'd0, 1'b0);
    #1;
    chk("full_pop_ready", 32'(lres_ready_o), 32'd0);
    cyc();
    lres_valid_i = 1'b1; lres_rd_i = 5'd14; lres_wd_i = 32'hC3;
    expect_wr(5'd13, 32'hC2, 32'd0, 1'b0);
    #1;
    chk("full_push_pop_ready", 32'(lres_ready_o), 32'd1);
    cyc();
    expect_wr(5'd14, 32'hC3, 32'd0, 1'b0);
    cyc();
    #1;
    chk("full_drained", 32'(busy_o), 32'd0);

    // Debug module blocks the drain.
    cyc();
    issue_valid_i = 1'b1; issue_rd_i = 5'd20;
    cyc();
    lres_valid_i = 1'b1; lres_rd_i = 5'd20; lres_wd_i = 32'hD0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      dm_wen_i = 1'b1; ra3_i = 5'd20;
      #1;
      chk("dbg_wen", 32'(wen_o), 32'd0);
      chk("dbg_hazard_ra3", 32'(hazard_o), 32'd1);
    end
    cyc();
    ra1_i = 5'd20;
    expect_wr(5'd20, 32'hD0, 32'd0, 1'b0);
    #1;
`ifdef AIRI5C_WB_FORWARD_EN
    chk("dbg_fwd1", 32'(fwd1_o), 32'd1);
    chk("dbg_fwd_hazard", 32'(hazard_o), 32'd0);
`else
    chk("dbg_drain_hazard", 32'(hazard_o), 32'd1);
`endif
    rd_chk_i = 5'd20;
    #1;
    chk("dbg_waw_hazard", 32'(hazard_o), 32'd1);
    cyc();
    ra1_i = 5'd20; rd_chk_i = 5'd20;
    #1;
    chk("dbg_after_hazard", 32'(hazard_o), 32'd0);
    chk("dbg_after_busy", 32'(busy_o), 32'd0);

    cyc();
    cyc();
    chk("expect_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
